// File: rtl/gate_selftest_checker_if.sv
// Bundle of stimulus, gate-response and status signals between the self-test
// checker (slave) and whatever drives/observes it (master).
interface gate_selftest_checker_if;
    logic       start_in;
    logic       a_out;
    logic       b_out;
    logic       not_in;
    logic       buf_in;
    logic       and_in;
    logic       or_in;
    logic       nand_in;
    logic       nor_in;
    logic       xor_in;
    logic       xnor_in;
    logic       busy_out;
    logic       done_out;
    logic       pass_out;
    logic [7:0] fail_vec_out;

    modport slave (
        input  start_in, not_in, buf_in, and_in, or_in, nand_in, nor_in, xor_in, xnor_in,
        output a_out, b_out, busy_out, done_out, pass_out, fail_vec_out
    );

    modport master (
        output start_in, not_in, buf_in, and_in, or_in, nand_in, nor_in, xor_in, xnor_in,
        input  a_out, b_out, busy_out, done_out, pass_out, fail_vec_out
    );
endinterface

// File: rtl/gate_selftest_checker.sv
// Walks the four A/B input vectors through a gate block under test, waits
// SETTLE_CYCLES per vector, and accumulates sticky per-gate mismatch flags.
module gate_selftest_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    gate_selftest_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    // Counter counts down to zero, so loading N-1 yields N settle cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] settle_cnt;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] fail_vec;
    logic [7:0] observed;
    logic [7:0] expected;
    logic [7:0] mismatch;
    logic       a;
    logic       b;

    assign a = idx[1];
    assign b = idx[0];

    assign observed = {bus.xnor_in, bus.xor_in, bus.nor_in, bus.nand_in,
                       bus.or_in,   bus.and_in, bus.buf_in, bus.not_in};

    always_comb begin
        expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, a, ~a};
        mismatch = observed ^ expected;
    end

    // NOTE: state is updated with non-blocking assignments so every branch
    // sees the pre-edge values of fail_vec, idx and settle_cnt.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        state      <= SETTLE;
                        idx        <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    fail_vec <= fail_vec | mismatch;
                    if (idx == 2'd3) begin
                        // Verdict must include this cycle's mismatches too.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= ((fail_vec | mismatch) == 8'h00);
                    end else begin
                        state      <= SETTLE;
                        idx        <= idx + 2'd1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    idx   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out        = a;
    assign bus.b_out        = b;
    assign bus.busy_out     = busy;
    assign bus.done_out     = done;
    assign bus.pass_out     = pass;
    assign bus.fail_vec_out = fail_vec;
endmodule

// File: tb/tb_gate_selftest_checker.sv
// Randomised self-test bench: a faultable gate model feeds two checker
// instances (SETTLE_CYCLES 2 and 1); expectations come from a timeline model.
module tb_gate_selftest_checker;
    typedef struct packed {
        logic [7:0] stuck_en;
        logic [7:0] stuck_val;
        logic [7:0] flip;
    } fault_t;

    localparam fault_t NO_FAULT = '{stuck_en: 8'h00, stuck_val: 8'h00, flip: 8'h00};

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    fault_t fault = NO_FAULT;
    logic [7:0] junk = 8'h00;
    int     n_checks = 0;
    int     n_fail = 0;

    gate_selftest_checker_if if0 ();
    gate_selftest_checker_if if1 ();

    gate_selftest_checker #(.SETTLE_CYCLES(2)) dut0 (.clk_in(clk), .rst_n_in(rst_n), .bus(if0.slave));
    gate_selftest_checker #(.SETTLE_CYCLES(1)) dut1 (.clk_in(clk), .rst_n_in(rst_n), .bus(if1.slave));

    always #5 clk = ~clk;

    // Truth table per gate, indexed by {a,b}.
    function automatic logic [3:0] truth_table(input int g);
        case (g)
            0:       return 4'b0011; // not
            1:       return 4'b1100; // buf
            2:       return 4'b1000; // and
            3:       return 4'b1110; // or
            4:       return 4'b0111; // nand
            5:       return 4'b0001; // nor
            6:       return 4'b0110; // xor
            default: return 4'b1001; // xnor
        endcase
    endfunction

    function automatic logic [7:0] gate_truth(input logic [1:0] v);
        logic [7:0] r;
        logic [3:0] t;
        for (int g = 0; g < 8; g++) begin
            t    = truth_table(g);
            r[g] = t[v];
        end
        return r;
    endfunction

    function automatic logic [7:0] model_resp(input logic [1:0] v, input fault_t f);
        logic [7:0] ideal;
        logic [7:0] r;
        ideal = gate_truth(v);
        for (int g = 0; g < 8; g++)
            r[g] = f.stuck_en[g] ? f.stuck_val[g] : (ideal[g] ^ f.flip[g]);
        return r;
    endfunction

    always_comb begin
        {if0.xnor_in, if0.xor_in, if0.nor_in, if0.nand_in, if0.or_in, if0.and_in, if0.buf_in, if0.not_in}
            = model_resp({if0.a_out, if0.b_out}, fault) ^ junk;
        {if1.xnor_in, if1.xor_in, if1.nor_in, if1.nand_in, if1.or_in, if1.and_in, if1.buf_in, if1.not_in}
            = model_resp({if1.a_out, if1.b_out}, fault) ^ junk;
    end

    // Start pulse (held for `hold` cycles) at cycle 0; optional reset at rst_at.
    // Cycle n is observed at the falling edge after the n-th rising edge.
    task automatic run_scenario(input string name, input bit sel, input fault_t f,
                                input int hold, input int rst_at, input int ncyc);
        int         s_cyc, len, s, rel;
        int         starts[$];
        logic [7:0] mism [4];
        logic [7:0] final_v, e_fail, o_fail;
        logic       e_busy, e_done, e_pass, e_a, e_b, chk_ab, is_check;
        logic       o_busy, o_done, o_pass, o_a, o_b;
        logic [1:0] kv;

        s_cyc   = sel ? 2 : 3;
        len     = 4 * s_cyc + 1;
        fault   = f;
        final_v = 8'h00;
        for (int k = 0; k < 4; k++) begin
            mism[k] = model_resp(2'(k), f) ^ gate_truth(2'(k));
            final_v |= mism[k];
        end
        s = 0;
        starts.push_back(0);
        while (s + len + 1 <= hold - 1) begin
            s += len + 1;
            starts.push_back(s);
        end

        rst_n = 1'b1;
        junk  = 8'($urandom);
        if (sel) if1.start_in = 1'b1; else if0.start_in = 1'b1;

        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            s = 0;
            foreach (starts[i]) if (starts[i] < n) s = starts[i];
            rel      = n - s;
            e_busy   = (rel <= len - 1);
            e_done   = (rel == len);
            chk_ab   = (rel != len);
            kv       = 2'((rel - 1) / s_cyc);
            e_a      = e_busy ? kv[1] : 1'b0;
            e_b      = e_busy ? kv[0] : 1'b0;
            e_pass   = (rel >= len) ? (final_v == 8'h00) : 1'b0;
            e_fail   = 8'h00;
            for (int k = 0; k < 4; k++) if ((k + 1) * s_cyc < rel) e_fail |= mism[k];
            is_check = e_busy && (rel % s_cyc == 0);
            if (rst_at >= 0 && n > rst_at) begin
                {e_busy, e_done, e_pass, e_a, e_b, e_fail} = '0;
                chk_ab   = 1'b1;
                is_check = 1'b0;
            end

            o_busy = sel ? if1.busy_out : if0.busy_out;
            o_done = sel ? if1.done_out : if0.done_out;
            o_pass = sel ? if1.pass_out : if0.pass_out;
            o_fail = sel ? if1.fail_vec_out : if0.fail_vec_out;
            o_a    = sel ? if1.a_out : if0.a_out;
            o_b    = sel ? if1.b_out : if0.b_out;

            n_checks += 4;
            if (o_busy !== e_busy) begin
                n_fail++;
                $display("FAIL %s cyc %0d busy: got %b expected %b", name, n, o_busy, e_busy);
            end
            if (o_done !== e_done) begin
                n_fail++;
                $display("FAIL %s cyc %0d done: got %b expected %b", name, n, o_done, e_done);
            end
            if (o_pass !== e_pass) begin
                n_fail++;
                $display("FAIL %s cyc %0d pass: got %b expected %b", name, n, o_pass, e_pass);
            end
            if (o_fail !== e_fail) begin
                n_fail++;
                $display("FAIL %s cyc %0d fail_vec: got %h expected %h", name, n, o_fail, e_fail);
            end
            if (chk_ab) begin
                n_checks++;
                if ({o_a, o_b} !== {e_a, e_b}) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d a/b: got %b%b expected %b%b", name, n, o_a, o_b, e_a, e_b);
                end
            end

            // Inputs for cycle n: garbage except when the DUT should sample.
            if (sel) if1.start_in = (n < hold); else if0.start_in = (n < hold);
            rst_n = (n != rst_at);
            junk  = is_check ? 8'h00 : 8'($urandom);
        end
        if0.start_in = 1'b0;
        if1.start_in = 1'b0;
        rst_n        = 1'b1;
        junk         = 8'h00;
    endtask

    task automatic test_reset();
        if0.start_in = 1'b1;
        if1.start_in = 1'b1;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 2;
        if ({if0.busy_out, if0.done_out, if0.pass_out, if0.a_out, if0.b_out, if0.fail_vec_out} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset dut0: got busy=%b done=%b pass=%b ab=%b%b fv=%h expected all zero",
                     if0.busy_out, if0.done_out, if0.pass_out, if0.a_out, if0.b_out, if0.fail_vec_out);
        end
        if ({if1.busy_out, if1.done_out, if1.pass_out, if1.a_out, if1.b_out, if1.fail_vec_out} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset dut1: got busy=%b done=%b pass=%b ab=%b%b fv=%h expected all zero",
                     if1.busy_out, if1.done_out, if1.pass_out, if1.a_out, if1.b_out, if1.fail_vec_out);
        end
        // Start was high throughout reset; it must not have launched a run.
        if0.start_in = 1'b0;
        if1.start_in = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({if0.busy_out, if1.busy_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_priority busy: got %b%b expected 00", if0.busy_out, if1.busy_out);
        end
    endtask

    task automatic test_correct();
        run_scenario("correct", 1'b0, NO_FAULT, 1, -1, 18);
    endtask

    task automatic test_and_stuck();
        run_scenario("and_stuck0", 1'b0, '{stuck_en: 8'h04, stuck_val: 8'h00, flip: 8'h00}, 1, -1, 16);
    endtask

    task automatic test_xor_swap();
        run_scenario("xor_swap", 1'b0, '{stuck_en: 8'h00, stuck_val: 8'h00, flip: 8'hC0}, 1, -1, 16);
        run_scenario("after_swap", 1'b0, NO_FAULT, 1, -1, 16);
    endtask

    task automatic test_random_faults();
        fault_t f;
        for (int i = 0; i < 8; i++) begin
            f.stuck_en  = 8'($urandom & $urandom);
            f.stuck_val = 8'($urandom);
            f.flip      = 8'($urandom & $urandom & $urandom);
            run_scenario("random", 1'(i % 2), f, 1, -1, 16);
        end
    endtask

    task automatic test_back_to_back();
        run_scenario("back_to_back", 1'b0, NO_FAULT, 20, -1, 32);
    endtask

    task automatic test_reset_mid_run();
        run_scenario("reset_mid_run", 1'b0, '{stuck_en: 8'h00, stuck_val: 8'h00, flip: 8'h01}, 1, 5, 10);
        run_scenario("after_reset", 1'b0, NO_FAULT, 1, -1, 16);
    endtask

    task automatic test_settle_one();
        run_scenario("settle1", 1'b1, NO_FAULT, 1, -1, 12);
        run_scenario("settle1_b2b", 1'b1, '{stuck_en: 8'h20, stuck_val: 8'h20, flip: 8'h00}, 12, -1, 24);
    endtask

    initial begin
        if0.start_in = 1'b0;
        if1.start_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_correct();
        test_and_stuck();
        test_xor_swap();
        test_random_faults();
        test_back_to_back();
        test_reset_mid_run();
        test_settle_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_selftest_checker.md
GATE_SELFTEST_CHECKER -- requirements
Module: gate_selftest_checker

Interface
REQ-001 Parameter SETTLE_CYCLES SHALL be provided: default 2; the number of cycles each stimulus vector is held before the gate responses are sampled; legal range 1..15.
REQ-002 Ports SHALL be as follows:
  clk_in        input   1  single clock; all logic on the rising edge
  rst_n_in      input   1  synchronous, active-low reset
  start_in      input   1  request a self-test run
  a_out         output  1  stimulus A to the gate block under test
  b_out         output  1  stimulus B to the gate block under test
  not_in        input   1  observed NOT(A)
  buf_in        input   1  observed BUF(A)
  and_in        input   1  observed A AND B
  or_in         input   1  observed A OR B
  nand_in       input   1  observed A NAND B
  nor_in        input   1  observed A NOR B
  xor_in        input   1  observed A XOR B
  xnor_in       input   1  observed A XNOR B
  busy_out      output  1  run in progress
  done_out      output  1  one-cycle run-complete pulse
  pass_out      output  1  last run had no mismatches
  fail_vec_out  output  8  sticky per-gate mismatch flags for the last run
REQ-003 fail_vec_out bit order SHALL be: [0] not, [1] buf, [2] and, [3] or, [4] nand, [5] nor, [6] xor, [7] xnor.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, SETTLE, CHECK, DONE.
REQ-005 A 2-bit vector index idx SHALL drive the stimulus: a_out = idx[1], b_out = idx[0]; vectors are applied in the order 00, 01, 10, 11.
REQ-006 IDLE: start_in=1 SHALL move the FSM to SETTLE, set idx=0, clear fail_vec_out and pass_out, and load the settle counter.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then move to CHECK.
REQ-008 CHECK (one cycle) SHALL compare all eight inputs against the expected function of the current a_out/b_out, and SHALL OR each mismatch into its fail_vec_out bit.
REQ-009 From CHECK: if idx != 3, the FSM SHALL increment idx and return to SETTLE; if idx = 3, it SHALL move to DONE.
REQ-010 DONE (one cycle) SHALL assert done_out=1, set pass_out = (final fail_vec_out == 0) including any CHECK-cycle update, and then move to IDLE.
REQ-011 busy_out SHALL be 1 in SETTLE and CHECK, and 0 in IDLE and DONE.
REQ-012 start_in SHALL be ignored in SETTLE, CHECK and DONE; no queuing.
REQ-013 Latency: with the start sampled at cycle 0, CHECK for vector k SHALL occur at cycle (k+1)*(SETTLE_CYCLES+1), and done_out SHALL be high at cycle 4*(SETTLE_CYCLES+1)+1.
REQ-014 pass_out and fail_vec_out SHALL hold their values from DONE until the next accepted start.
REQ-015 In IDLE, a_out and b_out SHALL be 0.
REQ-016 Inputs SHALL be sampled only in CHECK; changes on them in other states SHALL have no effect.

Reset
REQ-017 While rst_n_in=0 at a rising edge, the block SHALL enter IDLE with idx=0, a_out=0, b_out=0, busy_out=0, done_out=0, pass_out=0, fail_vec_out=8'h00.
REQ-018 Reset during a run SHALL abort the run immediately with no done_out pulse.
REQ-019 Reset SHALL take priority over start_in in the same cycle.

Verification
REQ-020 Correct gate model connected, SETTLE_CYCLES=2, start pulse at cycle 0 -> CHECK at cycles 3/6/9/12, done_out high at cycle 13 only, pass_out=1, fail_vec_out=8'h00.
REQ-021 and_in stuck at 0, otherwise correct -> mismatch at vector 11 only; at done: fail_vec_out=8'h04, pass_out=0.
REQ-022 xor_in and xnor_in swapped -> fail_vec_out=8'hC0, pass_out=0; a following correct run returns pass_out=1, fail_vec_out=8'h00.
REQ-023 start_in held high for 20 cycles from cycle 0 -> exactly one done_out pulse at cycle 13; next run begins at cycle 14 (IDLE sees start) with done_out at cycle 27.
REQ-024 rst_n_in=0 at cycle 5 of a run -> all outputs at reset values at cycle 6, no done_out; a new start then completes a full run with pass_out=1.
REQ-025 SETTLE_CYCLES=1, correct model -> done_out high at cycle 9, pass_out=1.
